// File: rtl/deb_pkg.sv
// Shared types and default constants for the raw-input debounce conditioner.
package deb_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'b00,
    CHK_HI = 2'b01,
    HIGH   = 2'b10,
    CHK_LO = 2'b11
  } deb_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_ff.sv
// Flop-chain synchronizer for a single asynchronous input bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/deb_entrada.sv
// Raw button/switch conditioner: synchronizer, stability filter, edge and long-press pulses.
//   state  | meaning
//   LOW    | level 0, waiting for synchronized input to go high
//   CHK_HI | input high, counting stable cycles before asserting level
//   HIGH   | level 1, hold timer running toward long press
//   CHK_LO | input low, counting stable cycles before dropping level
module deb_entrada
  import deb_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic clear_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (clear_n),
    .d     (raw_in),
    .q     (s)
  );

  deb_state_e       state, state_nxt;
  logic [CNT_W-1:0] stab_cnt, stab_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             long_done, done_nxt;
  logic             level_nxt, rise_nxt, fall_nxt, lp_nxt;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= LOW;
      stab_cnt   <= '0;
      hold_cnt   <= '0;
      long_done  <= 1'b0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_nxt;
      stab_cnt   <= stab_nxt;
      hold_cnt   <= hold_nxt;
      long_done  <= done_nxt;
      level      <= level_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      long_press <= lp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    hold_nxt  = hold_cnt;
    done_nxt  = long_done;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    lp_nxt    = 1'b0;
    case (state)
      LOW: begin
        level_nxt = 1'b0;
        if (s) begin
          state_nxt = CHK_HI;
          stab_nxt  = ONE;
        end else begin
          stab_nxt  = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_nxt = LOW;
          stab_nxt  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          stab_nxt  = '0;
          hold_nxt  = '0;
          done_nxt  = 1'b0;
        end else begin
          stab_nxt  = stab_cnt + ONE;
        end
      end
      HIGH: begin
        level_nxt = 1'b1;
        // Hold timer saturates at its terminal count; long_done makes the pulse one-shot.
        if (hold_cnt == HOLD_LAST) begin
          if (!long_done) begin
            lp_nxt   = 1'b1;
            done_nxt = 1'b1;
          end
        end else begin
          hold_nxt = hold_cnt + ONE;
        end
        if (!s) begin
          state_nxt = CHK_LO;
          stab_nxt  = ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_nxt = HIGH;
          stab_nxt  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          stab_nxt  = '0;
        end else begin
          stab_nxt  = stab_cnt + ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        level_nxt = 1'b0;
        stab_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_deb_entrada.sv
// Directed bench for deb_entrada with default parameters (6-edge latency, long press 16 after rise).
module tb_deb_entrada;

  logic clk = 1'b0;
  logic clear_n;
  logic raw_in;
  logic level, rise, fall, long_press;

  int n_tests = 0;
  int n_fail  = 0;

  deb_entrada dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .raw_in     (raw_in),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {level, rise, fall, long_press}.
  function automatic logic [3:0] obs();
    return {level, rise, fall, long_press};
  endfunction

  task automatic settle_low();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      raw_in = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_high(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      raw_in = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    clear_n = 1'b0;
    raw_in  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (obs() !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want 0000", obs());
    end
    @(negedge clk);
    clear_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp = {k >= 6, k == 6, 2'b00};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %b want %b", k, obs(), exp);
      end
    end
    settle_low();
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      raw_in = (k <= 3);
      @(posedge clk); #1;
      n_tests++;
      if (obs() !== 4'b0000) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got %b want 0000", k, obs());
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] exp;
    drive_high(8);
    n_tests++;
    if (level !== 1'b1) begin
      n_fail++;
      $display("FAIL release_setup: level got %b want 1", level);
    end
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      raw_in = 1'b0;
      @(posedge clk); #1;
      exp = {j < 6, 1'b0, j == 6, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL release edge %0d: got %b want %b", j, obs(), exp);
      end
    end
  endtask

  task automatic test_long_press();
    logic [3:0] exp;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      raw_in = 1'b1;
      @(posedge clk); #1;
      exp = {k >= 6, k == 6, 1'b0, k == 22};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL long_press edge %0d: got %b want %b", k, obs(), exp);
      end
    end
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      raw_in = 1'b0;
      @(posedge clk); #1;
      exp = {j < 6, 1'b0, j == 6, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL long_release edge %0d: got %b want %b", j, obs(), exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp;
    drive_high(8);
    // raw pattern 0,1,0,1 then steady 0: last falling step lands on j=5, so fall at j=10.
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      raw_in = (j == 2) || (j == 4);
      @(posedge clk); #1;
      exp = {j < 10, 1'b0, j == 10, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL bounce edge %0d: got %b want %b", j, obs(), exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp;
    // Reset while HIGH: level must drop before the next edge and no fall may follow.
    drive_high(8);
    n_tests++;
    if (level !== 1'b1) begin
      n_fail++;
      $display("FAIL async_high_setup: level got %b want 1", level);
    end
    @(negedge clk);
    #2 clear_n = 1'b0;
    raw_in = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_high_immediate: got %b want 0000", obs());
    end
    @(negedge clk);
    clear_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (obs() !== 4'b0000) begin
        n_fail++;
        $display("FAIL async_high_after edge %0d: got %b want 0000", k, obs());
      end
    end
    // Reset mid CHK_HI: partial count discarded, full latency needed afterwards.
    drive_high(4);
    @(negedge clk);
    #2 clear_n = 1'b0;
    raw_in = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_chk_immediate: got %b want 0000", obs());
    end
    @(negedge clk);
    clear_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (obs() !== 4'b0000) begin
        n_fail++;
        $display("FAIL async_chk_after edge %0d: got %b want 0000", k, obs());
      end
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      raw_in = 1'b1;
      @(posedge clk); #1;
      exp = {k >= 6, k == 6, 2'b00};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL async_chk_relatch edge %0d: got %b want %b", k, obs(), exp);
      end
    end
    settle_low();
  endtask

  initial begin
    clear_n = 1'b0;
    raw_in  = 1'b0;
    test_reset();
    test_glitch();
    test_release();
    settle_low();
    test_long_press();
    settle_low();
    test_bounce();
    settle_low();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deb_entrada.md
Name: deb_entrada

Overview:
- Input conditioner sitting directly upstream of the debounce-delay stage.
- Takes a raw, asynchronous mechanical input (button/switch) and passes it through a synchronizer, then a stability filter.
- Produces a clean level that drives the downstream stage's clear input.
- Also emits one-cycle rise/fall pulses and a one-shot long-press pulse for control logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- STABLE_CYCLES, 4, consecutive synchronized cycles at the new value required before `level` changes; must be ≥ 2.
- HOLD_CYCLES, 16, cycles `level` must stay 1 before `long_press` fires; must be > STABLE_CYCLES.
- CNT_W, 8, width of the internal counters; must hold HOLD_CYCLES-1.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- clear_n, input, 1, asynchronous active-low reset.
- raw_in, input, 1, unsynchronized raw input.
- level, output, 1, debounced level (registered).
- rise, output, 1, one-cycle pulse when `level` goes 0→1.
- fall, output, 1, one-cycle pulse when `level` goes 1→0.
- long_press, output, 1, one-cycle pulse after `level` has been 1 for HOLD_CYCLES cycles; fires once per press.

Behaviour:
- Reset (clear_n=0, asynchronous, any time): sync chain all 0, FSM in LOW, stab_cnt=0, hold_cnt=0, long_done=0. Outputs `level`, `rise`, `fall`, `long_press` all 0. Release is synchronous to the next clk edge. Reset mid-operation discards any partial count; no `fall` pulse is emitted.
- Synchronizer: raw_in shifts through SYNC_STAGES flops; `s` is the last stage. The FSM never uses raw_in directly.
- FSM states LOW, CHK_HI, HIGH, CHK_LO. All outputs are registered; `rise`, `fall` and `long_press` default to 0 every cycle.
  - LOW: level=0. If s=1, go to CHK_HI with stab_cnt=1. Otherwise stay, stab_cnt=0.
  - CHK_HI:
    - If s=0, go to LOW with stab_cnt=0 (glitch rejected, no pulse).
    - Else if stab_cnt==STABLE_CYCLES-1, go to HIGH: level<=1, rise<=1, stab_cnt=0, hold_cnt=0, long_done=0.
    - Else stab_cnt++.
  - HIGH: level=1. hold_cnt increments while below HOLD_CYCLES-1.
    - When hold_cnt==HOLD_CYCLES-1 and long_done=0: long_press<=1, long_done<=1. hold_cnt saturates there.
    - If s=0, go to CHK_LO with stab_cnt=1. Long-press processing in the same cycle still occurs.
  - CHK_LO: level stays 1; hold_cnt frozen.
    - If s=1, return to HIGH with stab_cnt=0 (no pulse, hold_cnt resumes).
    - Else if stab_cnt==STABLE_CYCLES-1, go to LOW: level<=0, fall<=1, stab_cnt=0.
    - Else stab_cnt++.
- Latency: raw_in stepping 0→1 and held asserts `level` and `rise` exactly SYNC_STAGES+STABLE_CYCLES rising edges later (6 with defaults). A 1→0 step is symmetric for `fall`.
- A `level` change is never accompanied by a pulse of the other type. `rise` and `fall` are never both 1 in the same cycle.
- Widths: counters are unsigned CNT_W and never wrap (hold_cnt saturates; stab_cnt is bounded by the FSM).
- Pulses alternate: rise, [long_press], fall, rise, …

Decomposition:
- Shared package `deb_pkg`: FSM state enum (LOW, CHK_HI, HIGH, CHK_LO, 2-bit encoding 00/01/10/11) and default parameter constants.
- One sub-module, `sync_ff`: a parameterised SYNC_STAGES flop chain with async active-low reset. It is instantiated once here and reused elsewhere for other raw inputs.

Test Plan:
- Reset: clear_n=0 with raw_in=1 → all outputs 0. Release while raw_in stays 1 → level=1 and rise=1 on the 6th edge after release, both checked cycle by cycle.
- Glitch rejection: raw_in high for 3 cycles, then low → level stays 0; rise, fall and long_press never pulse.
- Clean release: from level=1, raw_in low and held → fall=1 for exactly one cycle, 6 edges after the drop; level=0 from then on.
- Long press: raw_in held high for 40 cycles → single long_press pulse 16 cycles after rise; no repeat while held; fall follows after release.
- Bounce on release: from HIGH, raw_in pattern 0,1,0,1 then steady 0 → level stays 1 through the bounce; exactly one fall, 6 edges after the last 1→0 of raw_in.
- Async reset mid-CHK_HI: pull clear_n low between clock edges → outputs 0 immediately (before next edge); no pulses after release while raw_in=0.
